// File: rtl/imem_loader.sv
// imem_loader: receives a program over a byte stream (16-bit big-endian word
// count followed by big-endian 32-bit words) and writes it into instruction
// memory while holding the CPU in reset. All outputs are registered.
module imem_loader #(
  parameter int ROM_SIZE = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [30:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // Word counter only ever reaches ROM_SIZE-1, so this width never wraps.
  localparam int          CNT_W   = $clog2(ROM_SIZE + 1);
  localparam logic [15:0] MAX_LEN = 16'(ROM_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       byte_cnt;
  logic [15:0]      len_last;   // index of the final word, N-1
  logic [7:0]       len_hi;     // upper byte of N, held until the lower byte arrives
  logic [23:0]      shift_p0;   // first three bytes of the word being assembled
  logic [15:0]      len_rx;

  // Accept only lengths that fit the memory; zero-length loads are rejected.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && (n <= MAX_LEN);
  endfunction

  // Byte address of word k, same addressing as the fetch port.
  function automatic logic [30:0] word_addr(input logic [CNT_W-1:0] k);
    return 31'(k) << 2;
  endfunction

  // Big-endian assembly: earliest byte lands in bits [31:24].
  function automatic logic [31:0] assemble(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  assign len_rx = {len_hi, rx_data};

  // Byte capture datapath; only control state is reset, these are overwritten before use.
  always_ff @(posedge clk) begin
    if (!start && rx_valid) begin
      if (state == LEN_HI) len_hi   <= rx_data;
      if (state == DATA)   shift_p0 <= {shift_p0[15:0], rx_data};
    end
  end

  // Session FSM with registered outputs; start has priority over any byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      byte_cnt <= '0;
      len_last <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start) begin
        state    <= LEN_HI;
        word_cnt <= '0;
        byte_cnt <= '0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cpu_hold <= 1'b0;
          end
          LEN_HI: begin
            if (rx_valid) state <= LEN_LO;
          end
          LEN_LO: begin
            if (rx_valid) begin
              if (len_ok(len_rx)) begin
                len_last <= len_rx - 16'd1;
                state    <= DATA;
              end else begin
                error <= 1'b1;
                state <= ERR;
              end
            end
          end
          DATA: begin
            if (rx_valid) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                wr_en   <= 1'b1;
                wr_addr <= word_addr(word_cnt);
                wr_data <= assemble(shift_p0, rx_data);
                if (16'(word_cnt) == len_last) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                end else begin
                  word_cnt <= word_cnt + CNT_W'(1);
                end
              end
            end
          end
          DONE: begin
            cpu_hold <= 1'b0;
          end
          ERR: begin
            cpu_hold <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with immediate-assertion checks.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int base  = 0;

  logic [30:0] wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader #(.ROM_SIZE(160)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic s, input logic v, input logic [7:0] d);
    start    = s;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] pat(input int j);
    return 8'((j * 37 + 11) % 256);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    chk({tag, "_wr_data"},  wr_data,       32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_error"},    32'(error),    32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk_reset_vals("rst");

    // Reset overrides start
    step(1'b1, 1'b1, 8'h00);
    chk("rst_over_start_hold", 32'(cpu_hold), 32'd0);
    reset = 1'b0;
    idle(2);
    chk("idle_hold", 32'(cpu_hold), 32'd0);

    // Basic load with gaps between bytes
    base = wq_addr.size();
    step(1'b1, 1'b0, 8'h00);
    chk("basic_hold_start", 32'(cpu_hold), 32'd1);
    chk("basic_done_start", 32'(done), 32'd0);
    send(8'h00); idle(1);
    send(8'h02); idle(2);
    send(8'h08); send(8'h00); idle(1); send(8'h00);
    chk("basic_no_wr_yet", 32'(wr_en), 32'd0);
    send(8'h03);
    chk("basic_w0_en",   32'(wr_en),   32'd1);
    chk("basic_w0_addr", 32'(wr_addr), 32'd0);
    chk("basic_w0_data", wr_data,      32'h08000003);
    chk("basic_w0_done", 32'(done),    32'd0);
    chk("basic_w0_hold", 32'(cpu_hold), 32'd1);
    send(8'h3C);
    chk("basic_pulse_len", 32'(wr_en), 32'd0);
    chk("basic_hold_data", wr_data,    32'h08000003);
    send(8'h10); send(8'h40); send(8'h00);
    chk("basic_w1_en",   32'(wr_en),    32'd1);
    chk("basic_w1_addr", 32'(wr_addr),  32'd4);
    chk("basic_w1_data", wr_data,       32'h3C104000);
    chk("basic_done",    32'(done),     32'd1);
    chk("basic_hold0",   32'(cpu_hold), 32'd0);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    idle(1);
    chk("done_ignores_rx_en", 32'(wr_en),   32'd0);
    chk("done_keeps_addr",    32'(wr_addr), 32'd4);
    chk("done_keeps_done",    32'(done),    32'd1);
    chk("basic_nwr", 32'(wq_addr.size() - base), 32'd2);

    // Bad length: N=161 then N=0
    base = wq_addr.size();
    step(1'b1, 1'b0, 8'h00);
    chk("bad_done_cleared", 32'(done), 32'd0);
    send(8'h00); send(8'hA1);
    chk("bad161_error", 32'(error),    32'd1);
    chk("bad161_hold",  32'(cpu_hold), 32'd1);
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    step(1'b1, 1'b0, 8'h00);
    chk("bad_err_cleared", 32'(error), 32'd0);
    send(8'h00); send(8'h00);
    chk("bad0_error", 32'(error),    32'd1);
    chk("bad0_hold",  32'(cpu_hold), 32'd1);
    idle(2);
    chk("bad_nwr", 32'(wq_addr.size() - base), 32'd0);

    // Maximum length, back-to-back bytes
    base = wq_addr.size();
    step(1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'hA0);
    for (int j = 0; j < 640; j++) send(pat(j));
    chk("max_last_en",   32'(wr_en),    32'd1);
    chk("max_last_addr", 32'(wr_addr),  32'h27C);
    chk("max_done",      32'(done),     32'd1);
    chk("max_hold0",     32'(cpu_hold), 32'd0);
    chk("max_error",     32'(error),    32'd0);
    idle(2);
    chk("max_nwr", 32'(wq_addr.size() - base), 32'd160);
    if (wq_addr.size() - base == 160) begin
      for (int k = 0; k < 160; k++) begin
        chk($sformatf("max_addr_%0d", k), 32'(wq_addr[base + k]), 32'(4 * k));
        chk($sformatf("max_data_%0d", k), wq_data[base + k],
            {pat(4 * k), pat(4 * k + 1), pat(4 * k + 2), pat(4 * k + 3)});
      end
    end

    // Abort mid-session
    base = wq_addr.size();
    step(1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    step(1'b1, 1'b0, 8'h00);
    chk("abort_done0", 32'(done), 32'd0);
    send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    chk("abort_no_early_wr", 32'(wr_en), 32'd0);
    send(8'h44);
    chk("abort_en",   32'(wr_en),   32'd1);
    chk("abort_addr", 32'(wr_addr), 32'd0);
    chk("abort_data", wr_data,      32'h11223344);
    chk("abort_done", 32'(done),    32'd1);
    idle(1);
    chk("abort_nwr", 32'(wq_addr.size() - base), 32'd1);

    // Reset in the middle of a word
    base = wq_addr.size();
    step(1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    reset = 1'b1;
    step(1'b0, 1'b1, 8'h56);
    reset = 1'b0;
    chk_reset_vals("midrst");
    send(8'h78); send(8'h9A); send(8'hBC); send(8'hDE);
    idle(2);
    chk("midrst_nwr",  32'(wq_addr.size() - base), 32'd0);
    chk("midrst_done", 32'(done),     32'd0);
    chk("midrst_hold", 32'(cpu_hold), 32'd0);

    // Start collides with a byte: the byte is dropped
    base = wq_addr.size();
    step(1'b1, 1'b1, 8'h05);
    send(8'h00); send(8'h01);
    chk("coll_error", 32'(error),    32'd0);
    chk("coll_hold",  32'(cpu_hold), 32'd1);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("coll_en",   32'(wr_en),   32'd1);
    chk("coll_addr", 32'(wr_addr), 32'd0);
    chk("coll_data", wr_data,      32'hDEADBEEF);
    chk("coll_done", 32'(done),    32'd1);
    idle(1);
    chk("coll_nwr", 32'(wq_addr.size() - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 160, instruction-memory depth in 32-bit words.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a new load session.
REQ-005 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  single-cycle strobe; rx_data is valid when high.
REQ-007 SHALL have port wr_en  output  1  single-cycle write strobe to instruction memory.
REQ-008 SHALL have port wr_addr  output  31  byte address of the word written, word-aligned, same addressing as the fetch port.
REQ-009 SHALL have port wr_data  output  32  instruction word to write.
REQ-010 SHALL have port cpu_hold  output  1  high while loading; holds the CPU in reset.
REQ-011 SHALL have port done  output  1  high after a successful load, until the next start or reset.
REQ-012 SHALL have port error  output  1  high after a rejected load, until the next start or reset.

Function
REQ-013 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, DONE and ERR.
REQ-014 IDLE: cpu_hold=0; start -> LEN_HI; clear done, error, word counter and byte counter.
REQ-015 LEN_HI: the first rx_valid byte is the upper byte of the 16-bit word count N -> LEN_LO.
REQ-016 LEN_LO: the next rx_valid byte is the lower byte of N; if N==0 or N>ROM_SIZE -> ERR, else -> DATA.
REQ-017 DATA: bytes are assembled big-endian; the first byte of each group of four is bits [31:24].
REQ-018 On the 4th byte of word k (k = 0..N-1), wr_en SHALL pulse exactly one cycle after that rx_valid cycle, with wr_addr = 4*k and wr_data = the assembled word.
REQ-019 After the write of word N-1, the FSM SHALL go to DONE in the same cycle as that wr_en.
REQ-020 DONE: done=1, cpu_hold=0; rx_valid is ignored; start -> LEN_HI (new session, counters cleared).
REQ-021 ERR: error=1, cpu_hold=1; rx_valid is ignored; start -> LEN_HI.
REQ-022 cpu_hold SHALL be 1 in LEN_HI, LEN_LO, DATA and ERR, and 0 in IDLE and DONE.
REQ-023 A start pulse in LEN_HI, LEN_LO or DATA SHALL abort the session and restart at LEN_HI with counters cleared; words already written stay in memory.
REQ-024 start and rx_valid in the same cycle: start wins and the byte is discarded.
REQ-025 wr_addr SHALL never exceed 4*(ROM_SIZE-1); the word counter SHALL never wrap.
REQ-026 wr_data and wr_addr SHALL hold their last values when wr_en=0.
REQ-027 rx_valid may assert on consecutive cycles; no byte SHALL be lost at one byte per cycle.
REQ-028 The block SHALL have no combinational path from inputs to outputs; all outputs are registered.

Reset
REQ-029 reset SHALL override start and rx_valid.
REQ-030 On reset: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0; all counters 0.
REQ-031 Reset in the middle of DATA SHALL abandon the partial word; no further wr_en until a new session.

Verification
REQ-032 Basic load: start; bytes 00 02 08 00 00 03 3C 10 40 00 -> wr_en at addr 0 data 0x08000003, wr_en at addr 4 data 0x3C104000; then done=1 and cpu_hold=0.
REQ-033 Bad length: start; bytes 00 A1 (N=161) -> error=1 and cpu_hold=1, no wr_en; bytes 00 00 (N=0) -> same result.
REQ-034 Maximum length: N=160 with back-to-back rx_valid -> 160 writes, last at addr 0x27C, done=1, no lost bytes.
REQ-035 Abort: start; 00 01 AA BB, then start, then 00 01 11 22 33 44 -> single wr_en at addr 0 data 0x11223344, done=1.
REQ-036 Reset mid-word: N=1, two data bytes, then reset -> all outputs at reset values; further bytes produce no wr_en.
REQ-037 Collision: start asserted in the same cycle as an rx_valid byte -> byte ignored; the next byte is taken as LEN_HI.
